// File: rtl/rf_pkg.sv
// Shared types, default sizing and commit-port unpack helpers for the rename/status register file.
package rf_pkg;

  localparam int unsigned RF_REG_WIDTH    = 5;
  localparam int unsigned RF_ROB_WIDTH    = 4;
  localparam int unsigned RF_XLEN         = 32;
  localparam int unsigned RF_COMMIT_PORTS = 2;

  typedef logic [RF_ROB_WIDTH:0]   tag_t;
  typedef logic [RF_REG_WIDTH-1:0] reg_idx_t;

  // Where an operand read takes its Q/V from.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BYPASS,
    SRC_PENDING,
    SRC_REGFILE
  } opnd_src_e;

  // Tag value meaning "no dependency": the single bit above the ROB index range.
  function automatic int unsigned non_dep(input int unsigned rob_w);
    return 32'd1 << rob_w;
  endfunction

  localparam tag_t NON_DEP = tag_t'(non_dep(RF_ROB_WIDTH));

  // LSB of port p inside a packed commit bus with per-port width w.
  function automatic int unsigned port_lsb(input int unsigned p, input int unsigned w);
    return p * w;
  endfunction

endpackage

// File: rtl/rf_operand_lookup.sv
// One source operand's Q/V selection: x0/unused, same-cycle commit bypass, pending tag or regfile value.
module rf_operand_lookup
  import rf_pkg::*;
#(
  parameter int unsigned ROB_WIDTH    = RF_ROB_WIDTH,
  parameter int unsigned XLEN         = RF_XLEN,
  parameter int unsigned COMMIT_PORTS = RF_COMMIT_PORTS
) (
  input  logic                            i_src_vld,
  input  logic                            i_src_is_x0,
  input  logic                            i_flush,
  input  logic                            i_busy,
  input  logic [ROB_WIDTH:0]              i_tag,
  input  logic [XLEN-1:0]                 i_reg_val,
  input  logic [COMMIT_PORTS-1:0]         i_commit_en,
  input  logic [COMMIT_PORTS*ROB_WIDTH-1:0] i_commit_index,
  input  logic [COMMIT_PORTS*XLEN-1:0]    i_commit_value,
  output logic [ROB_WIDTH:0]              o_q,
  output logic [XLEN-1:0]                 o_v
);

  localparam logic [ROB_WIDTH:0] NON_DEP_TAG = (ROB_WIDTH+1)'(non_dep(ROB_WIDTH));

  logic            w_hit;
  logic [XLEN-1:0] w_hit_val;
  opnd_src_e       w_src;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_val = '0;
    for (int unsigned p = 0; p < COMMIT_PORTS; p++) begin
      if (i_commit_en[p] &&
          i_tag == {1'b0, i_commit_index[port_lsb(p, ROB_WIDTH) +: ROB_WIDTH]}) begin
        w_hit     = 1'b1;
        w_hit_val = i_commit_value[port_lsb(p, XLEN) +: XLEN];
      end
    end
  end

  always_comb begin
    if (!i_src_vld || i_src_is_x0) w_src = SRC_NONE;
    else if (i_busy && w_hit)      w_src = SRC_BYPASS;
    else if (i_busy)               w_src = SRC_PENDING;
    else                           w_src = SRC_REGFILE;
  end

  always_comb begin
    o_q = NON_DEP_TAG;
    o_v = '0;
    case (w_src)
      SRC_BYPASS:  o_v = w_hit_val;
      SRC_PENDING: o_q = i_tag;
      SRC_REGFILE: o_v = i_reg_val;
      default:     ;
    endcase
    // The dispatch is discarded during recovery, so no tag may escape.
    if (i_flush) o_q = NON_DEP_TAG;
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy/ROB-tag rename state, multi-port commit and flush.
module reg_status_file
  import rf_pkg::*;
#(
  parameter int unsigned REG_WIDTH    = RF_REG_WIDTH,
  parameter int unsigned ROB_WIDTH    = RF_ROB_WIDTH,
  parameter int unsigned XLEN         = RF_XLEN,
  parameter int unsigned COMMIT_PORTS = RF_COMMIT_PORTS
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              DP2RF_en,
  input  logic [REG_WIDTH-1:0]              DP2RF_rs1,
  input  logic [REG_WIDTH-1:0]              DP2RF_rs2,
  input  logic                              DP2RF_rs1_vld,
  input  logic                              DP2RF_rs2_vld,
  input  logic [REG_WIDTH-1:0]              DP2RF_rd,
  input  logic                              DP2RF_rd_vld,
  input  logic [ROB_WIDTH-1:0]              DP2RF_ROB_index,
  output logic [ROB_WIDTH:0]                RF2DP_Qj,
  output logic [ROB_WIDTH:0]                RF2DP_Qk,
  output logic [XLEN-1:0]                   RF2DP_Vj,
  output logic [XLEN-1:0]                   RF2DP_Vk,
  input  logic                              ROB2RF_flush,
  input  logic [COMMIT_PORTS-1:0]           ROB2RF_commit_en,
  input  logic [COMMIT_PORTS*REG_WIDTH-1:0] ROB2RF_commit_rd,
  input  logic [COMMIT_PORTS*ROB_WIDTH-1:0] ROB2RF_commit_index,
  input  logic [COMMIT_PORTS*XLEN-1:0]      ROB2RF_commit_value,
  output logic [REG_WIDTH:0]                RF2DP_busy_cnt
);

  localparam int unsigned        NREG        = 1 << REG_WIDTH;
  localparam logic [ROB_WIDTH:0] NON_DEP_TAG = (ROB_WIDTH+1)'(non_dep(ROB_WIDTH));

  logic [XLEN-1:0]      r_regs [NREG];
  logic [NREG-1:0]      r_busy;
  logic [ROB_WIDTH:0]   r_tag  [NREG];
  logic [REG_WIDTH:0]   r_busy_cnt;

  logic [REG_WIDTH-1:0] w_crd  [COMMIT_PORTS];
  logic [ROB_WIDTH-1:0] w_cidx [COMMIT_PORTS];
  logic [XLEN-1:0]      w_cval [COMMIT_PORTS];
  logic [COMMIT_PORTS-1:0] w_cwr;

  logic [NREG-1:0]      w_busy_nxt;
  logic [ROB_WIDTH:0]   w_tag_nxt [NREG];
  logic [REG_WIDTH:0]   w_busy_cnt_nxt;
  logic                 w_rename;

  always_comb begin
    for (int unsigned p = 0; p < COMMIT_PORTS; p++) begin
      w_crd[p]  = ROB2RF_commit_rd[port_lsb(p, REG_WIDTH) +: REG_WIDTH];
      w_cidx[p] = ROB2RF_commit_index[port_lsb(p, ROB_WIDTH) +: ROB_WIDTH];
      w_cval[p] = ROB2RF_commit_value[port_lsb(p, XLEN) +: XLEN];
      w_cwr[p]  = ROB2RF_commit_en[p] && (w_crd[p] != '0);
    end
  end

  assign w_rename = DP2RF_en && DP2RF_rd_vld && (DP2RF_rd != '0) && !ROB2RF_flush;

  // Each commit evaluates against pre-edge state; later (younger) ports overwrite earlier results,
  // then rename overrides any clear, then flush overrides everything.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 0; i < NREG; i++) w_tag_nxt[i] = r_tag[i];
    for (int unsigned p = 0; p < COMMIT_PORTS; p++) begin
      if (w_cwr[p])
        w_busy_nxt[w_crd[p]] = r_busy[w_crd[p]] && (r_tag[w_crd[p]] != {1'b0, w_cidx[p]});
    end
    if (w_rename) begin
      w_busy_nxt[DP2RF_rd] = 1'b1;
      w_tag_nxt[DP2RF_rd]  = {1'b0, DP2RF_ROB_index};
    end
    if (ROB2RF_flush) begin
      w_busy_nxt = '0;
      for (int unsigned i = 0; i < NREG; i++) w_tag_nxt[i] = NON_DEP_TAG;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++)
      w_busy_cnt_nxt = w_busy_cnt_nxt + (REG_WIDTH+1)'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= NON_DEP_TAG;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else if (rdy_in) begin
      for (int unsigned p = 0; p < COMMIT_PORTS; p++) begin
        if (w_cwr[p]) r_regs[w_crd[p]] <= w_cval[p];
      end
      for (int unsigned i = 0; i < NREG; i++) r_tag[i] <= w_tag_nxt[i];
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign RF2DP_busy_cnt = r_busy_cnt;

  rf_operand_lookup #(
    .ROB_WIDTH    (ROB_WIDTH),
    .XLEN         (XLEN),
    .COMMIT_PORTS (COMMIT_PORTS)
  ) u_lookup_rs1 (
    .i_src_vld      (DP2RF_rs1_vld),
    .i_src_is_x0    (DP2RF_rs1 == '0),
    .i_flush        (ROB2RF_flush),
    .i_busy         (r_busy[DP2RF_rs1]),
    .i_tag          (r_tag[DP2RF_rs1]),
    .i_reg_val      (r_regs[DP2RF_rs1]),
    .i_commit_en    (ROB2RF_commit_en),
    .i_commit_index (ROB2RF_commit_index),
    .i_commit_value (ROB2RF_commit_value),
    .o_q            (RF2DP_Qj),
    .o_v            (RF2DP_Vj)
  );

  rf_operand_lookup #(
    .ROB_WIDTH    (ROB_WIDTH),
    .XLEN         (XLEN),
    .COMMIT_PORTS (COMMIT_PORTS)
  ) u_lookup_rs2 (
    .i_src_vld      (DP2RF_rs2_vld),
    .i_src_is_x0    (DP2RF_rs2 == '0),
    .i_flush        (ROB2RF_flush),
    .i_busy         (r_busy[DP2RF_rs2]),
    .i_tag          (r_tag[DP2RF_rs2]),
    .i_reg_val      (r_regs[DP2RF_rs2]),
    .i_commit_en    (ROB2RF_commit_en),
    .i_commit_index (ROB2RF_commit_index),
    .i_commit_value (ROB2RF_commit_value),
    .o_q            (RF2DP_Qk),
    .o_v            (RF2DP_Vk)
  );

endmodule
